// File: rtl/fp16_stream_accum.sv
// fp16_stream_accum: streaming FP16 packet reducer built around one
// combinational adder_fp16. Operands arrive on a valid/ready input, the packet
// sum and operand count leave on a valid/ready output.
// Optional build macro FP16_ACC_FLAGS_EN adds the sticky out_flags port
// {saw_nan, saw_inf}.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for the first operand of a packet (loaded, not added)
// S_ACC  | accumulating operands until the in_last beat
// S_DONE | sum and count presented on the output, waiting for out_ready

// adder_fp16: combinational FP16 adder. The result is truncated toward zero,
// overflows to +/-inf, flushes results below the smallest normal to signed
// zero, and returns 16'h7E00 for any NaN result.
module adder_fp16 #(
    parameter int IMPL_TYPE = 0
) (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);

    logic [15:0]        x;
    logic [15:0]        y;
    logic               x_nan;
    logic               y_nan;
    logic               x_inf;
    logic               y_inf;
    logic signed [41:0] sum_s;
    logic [41:0]        mag;
    logic [5:0]         lead;
    logic [9:0]         mant;
    logic               sgn;

    // Both operands become exact fixed-point integers with LSB 2^-24; every
    // finite FP16 value fits in 40 bits, so the add itself is exact.
    function automatic logic [41:0] to_fix(input logic [15:0] h);
        logic [41:0] m;
        if (h[14:10] == 5'd0) begin
            m = {32'd0, h[9:0]};
        end else begin
            m = {31'd0, 1'b1, h[9:0]} << (h[14:10] - 5'd1);
        end
        return m;
    endfunction

    // IMPL_TYPE selects operand order into the datapath; the datapath is
    // symmetric, so both orders give identical sums.
    assign x = (IMPL_TYPE == 0) ? a_i : b_i;
    assign y = (IMPL_TYPE == 0) ? b_i : a_i;

    assign x_nan = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    assign y_nan = (y[14:10] == 5'h1F) && (y[9:0] != 10'd0);
    assign x_inf = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    assign y_inf = (y[14:10] == 5'h1F) && (y[9:0] == 10'd0);

    // Exact signed sum, leading-one search, truncating renormalisation.
    always_comb begin
        sum_s = (x[15] ? -$signed(to_fix(x)) : $signed(to_fix(x)))
              + (y[15] ? -$signed(to_fix(y)) : $signed(to_fix(y)));
        sgn   = sum_s[41];
        mag   = sgn ? $unsigned(-sum_s) : $unsigned(sum_s);
        lead  = 6'd0;
        for (int i = 0; i < 42; i++) begin
            if (mag[i]) lead = 6'(i);
        end
        mant  = 10'(mag >> (lead - 6'd10));
        sum_o = 16'h7E00;
        if (x_nan || y_nan || (x_inf && y_inf && (x[15] != y[15]))) begin
            sum_o = 16'h7E00;
        end else if (x_inf) begin
            sum_o = {x[15], 5'h1F, 10'd0};
        end else if (y_inf) begin
            sum_o = {y[15], 5'h1F, 10'd0};
        end else if (mag == 42'd0) begin
            // exact zero: -0 only when both operands were -0
            sum_o = {x[15] & y[15], 15'd0};
        end else if (lead < 6'd10) begin
            sum_o = {sgn, 15'd0};
        end else if (lead > 6'd39) begin
            sum_o = {sgn, 5'h1F, 10'd0};
        end else begin
            sum_o = {sgn, 5'(lead - 6'd9), mant};
        end
    end

endmodule

module fp16_stream_accum #(
    parameter int IMPL_TYPE = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count
`ifdef FP16_ACC_FLAGS_EN
    ,
    output logic [1:0]       out_flags
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q;
    logic [15:0]      acc_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             out_valid_q;
    logic [15:0]      sum_d;
    logic             beat;

    adder_fp16 #(
        .IMPL_TYPE(IMPL_TYPE)
    ) u_adder (
        .a_i  (acc_q),
        .b_i  (in_data),
        .sum_o(sum_d)
    );

    // in_ready is the only output decoded straight from state.
    assign in_ready  = (state_q != S_DONE);
    assign beat      = in_valid && in_ready;
    assign count_d   = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_count = count_q;

    // Packet FSM: load first operand, accumulate, then hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= 16'h0000;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (beat) begin
                        acc_q   <= in_data;
                        count_q <= CNT_W'(1);
                        if (in_last) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_ACC;
                        end
                    end
                end
                S_ACC: begin
                    if (beat) begin
                        acc_q   <= sum_d;
                        count_q <= count_d;
                        if (in_last) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        count_q     <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FP16_ACC_FLAGS_EN
    logic [1:0] flags_q;

    function automatic logic [1:0] classify(input logic [15:0] h);
        return {(h[14:10] == 5'h1F) && (h[9:0] != 10'd0),
                (h[14:10] == 5'h1F) && (h[9:0] == 10'd0)};
    endfunction

    // Sticky {saw_nan, saw_inf}; restart on the first operand of a packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 2'b00;
        end else if (beat) begin
            if (state_q == S_IDLE) begin
                flags_q <= classify(in_data);
            end else begin
                flags_q <= flags_q | classify(in_data) | classify(sum_d);
            end
        end
    end

    assign out_flags = flags_q;
`endif

endmodule
